// File: rtl/fp32_16_if.sv
// Handshake bundle for the fp32 -> fp16 converter: operand in, result and flags out.
interface fp32_16_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in32;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out16;
  logic [3:0]  flags;

  modport master (
    output in_valid,
    output in32,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out16,
    input  flags
  );

  modport slave (
    input  in_valid,
    input  in32,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out16,
    output flags
  );
endinterface

// File: rtl/fp32_16.sv
// Multi-cycle IEEE-754 binary32 -> binary16 converter, round-to-nearest-even.
// Subnormal results are denormalised one bit per cycle before rounding.
module fp32_16 #(
  parameter bit FTZ = 1'b0
) (
  input logic       clk,
  input logic       reset,
  fp32_16_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StRound, StDone} state_e;

  state_e      state_q;
  logic        sign_q;
  logic [4:0]  exp5_q;
  logic [23:0] w_q;
  logic        sticky_q;
  logic [3:0]  cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [15:0] out16_q;
  logic [3:0]  flags_q;

  logic               in_sign;
  logic [7:0]         in_exp;
  logic [22:0]        in_frac;
  logic signed [8:0]  in_e;
  logic               accept;

  assign in_sign = bus.in32[31];
  assign in_exp  = bus.in32[30:23];
  assign in_frac = bus.in32[22:0];
  // Unbiased exponent rebased to fp16 bias: 127 - 15 = 112.
  assign in_e    = $signed({1'b0, in_exp}) - 9'sd112;
  assign accept  = bus.in_valid & in_ready_q;

  logic [9:0]  rnd_m;
  logic        rnd_g;
  logic        rnd_s;
  logic        rnd_inc;
  logic [14:0] rnd_mag;
  logic        rnd_inexact;
  logic        rnd_ovf;
  logic        rnd_unf;

  always_comb begin
    rnd_m       = w_q[22:13];
    rnd_g       = w_q[12];
    rnd_s       = (|w_q[11:0]) | sticky_q;
    rnd_inc     = rnd_g & (rnd_s | rnd_m[0]);
    // Mantissa carry ripples into the exponent field; 30 + 1 cannot exceed 5 bits.
    rnd_mag     = {exp5_q, rnd_m} + {14'd0, rnd_inc};
    rnd_inexact = rnd_g | rnd_s;
    rnd_ovf     = (rnd_mag[14:10] == 5'h1F);
    rnd_unf     = (exp5_q == 5'd0) & rnd_inexact;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      exp5_q      <= 5'd0;
      w_q         <= 24'd0;
      sticky_q    <= 1'b0;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out16_q     <= 16'h0000;
      flags_q     <= 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            sign_q     <= in_sign;
            w_q        <= {1'b1, in_frac};
            sticky_q   <= 1'b0;
            if (in_exp == 8'hFF) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              if (in_frac != 23'd0) begin
                // Quiet the NaN; signalling input raises invalid.
                out16_q <= {in_sign, 5'h1F, 1'b1, in_frac[21:13]};
                flags_q <= {~in_frac[22], 3'b000};
              end else begin
                out16_q <= {in_sign, 15'h7C00};
                flags_q <= 4'h0;
              end
            end else if (in_exp == 8'h00) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              out16_q     <= {in_sign, 15'h0000};
              flags_q     <= {2'b00, {2{in_frac != 23'd0}}};
            end else if (in_e >= 9'sd31) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              out16_q     <= {in_sign, 15'h7C00};
              flags_q     <= 4'b0101;
            end else if (in_e >= 9'sd1) begin
              exp5_q  <= in_e[4:0];
              state_q <= StRound;
            end else if ((in_e < -9'sd10) || FTZ) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              out16_q     <= {in_sign, 15'h0000};
              flags_q     <= 4'b0011;
            end else begin
              exp5_q  <= 5'd0;
              cnt_q   <= 4'(9'sd1 - in_e);
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          w_q      <= w_q >> 1;
          sticky_q <= sticky_q | w_q[0];
          cnt_q    <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StRound;
          end
        end
        StRound: begin
          out16_q     <= {sign_q, rnd_mag};
          flags_q     <= {1'b0, rnd_ovf, rnd_unf, rnd_inexact};
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out16     = out16_q;
  assign bus.flags     = flags_q;

endmodule

// File: doc/fp32_16.md
FP32_16 -- requirements
Module: fp32_16

Parameters
REQ-001 SHALL provide parameter FTZ, default 0; when 1, results that would be fp16 subnormal are flushed to ±0.

Interface
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in32 holds a valid operand.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-006 SHALL have port in32, input, 32 bits: IEEE-754 binary32 operand.
REQ-007 SHALL have port out_valid, output, 1 bit: out16 and flags hold a valid result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port out16, output, 16 bits: IEEE-754 binary16 result.
REQ-010 SHALL have port flags, output, 4 bits: {invalid, overflow, underflow, inexact}.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, ROUND, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL accept an operand on an edge with in_valid && in_ready, latch it, and classify it on that same edge.
REQ-013 SHALL compute signed 9-bit e = exp32 - 112, and working significand W[23:0] = {1, frac32}.
REQ-014 SHALL handle NaN (exp32 = 255, frac ≠ 0) as follows: out16 = {sign, 5'h1F, 1, frac32[21:13]}; invalid = ~frac32[22]; next state DONE.
REQ-015 SHALL handle Inf (exp32 = 255, frac = 0) as follows: out16 = {sign, 15'h7C00}; flags = 0; next state DONE.
REQ-016 SHALL handle exp32 = 0 (zero or fp32 subnormal) as follows: out16 = ±0; if frac ≠ 0, set underflow and inexact; next state DONE.
REQ-017 SHALL handle e ≥ 31 as follows: out16 = ±Inf; set overflow and inexact; next state DONE.
REQ-018 SHALL handle 1 ≤ e ≤ 30 as follows: next state ROUND with exp5 = e[4:0].
REQ-019 SHALL handle e ≤ 0 as follows:
 - if e < -10, or FTZ = 1: out16 = ±0, set underflow and inexact, next state DONE;
 - otherwise: exp5 = 0, load shift counter with 1 - e (range 1..11), next state SHIFT.
REQ-020 SHALL, in SHIFT, each cycle: W >>= 1; sticky |= bit shifted out; counter decrements; on reaching 0, go to ROUND.
REQ-021 SHALL, in ROUND, compute result using round-to-nearest-even:
 - M = W[22:13], G = W[12], S = |W[11:0] | sticky;
 - result = {sign, exp5, M} + (G & (S | M[0])), with mantissa carry propagating into the exponent;
 - next state DONE.
REQ-022 SHALL set flags in ROUND as follows:
 - inexact = G | S;
 - underflow = (exp5 was 0) & inexact;
 - overflow = (rounded exponent == 31), in which case out16 is exactly ±Inf.
REQ-023 SHALL meet this latency from the accepting edge t:
 - special/flush cases: out_valid at t+1;
 - normal: t+2;
 - subnormal: t+2+(1-e).
REQ-024 SHALL hold out16 and flags stable while out_valid && !out_ready; on an edge with out_valid && out_ready, go to IDLE.
REQ-025 SHALL hold out16 and flags at their last values in IDLE and SHIFT, and update them only on entry to DONE.
REQ-026 SHALL NOT accept a new operand during SHIFT, ROUND, or DONE; in_ready = 0 in those states, so there is no overlap.

Reset
REQ-027 SHALL, on reset assertion, immediately set state = IDLE, out_valid = 0, out16 = 16'h0000, flags = 4'h0, and clear the counter and sticky.
REQ-028 SHALL drive in_ready = 0 while reset is high, and 1 from the first edge after deassertion.
REQ-029 SHALL, on reset during SHIFT, ROUND, or DONE, discard the in-flight result with no out_valid pulse.

Verification
REQ-030 SHALL cover: in32 = 0x3F800000 accepted at t → out16 = 0x3C00, flags = 0, out_valid at t+2.
REQ-031 SHALL cover: in32 = 0x477FF000 (65520, tie) → out16 = 0x7C00, flags = 4'b0101 (overflow, inexact).
REQ-032 SHALL cover: in32 = 0x33800000 (2^-24) → 10 SHIFT cycles, out16 = 0x0001, flags = 0, out_valid at t+12; same input with FTZ = 1 → out16 = 0x0000, flags = 4'b0011 at t+1.
REQ-033 SHALL cover: in32 = 0x7F800001 (sNaN) → out16 = 0x7E00, flags = 4'b1000; in32 = 0xFF800000 → out16 = 0xFC00, flags = 0.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles after out_valid → out16/flags stable, in_ready = 0; result released and in_ready = 1 on the edge after out_ready = 1.
REQ-035 SHALL cover: reset asserted mid-SHIFT (in32 = 0x33800000, cycle t+4) → out_valid = 0 immediately, no result ever produced, next operand converts correctly.
